// File: rtl/pc_gen_unit.sv
// -----------------------------------------------------------------------------
// pc_gen_unit
//
// Fetch-stage program-counter generator. Produces the instruction-fetch
// address and the instruction-memory chip enable. Next-PC priority is
// flush (exception/trap), then branch, then sequential increment by STEP.
// A branch raised while the fetch is not accepted is buffered and applied
// on the next accepted cycle. An accepted-fetch counter is also kept.
//
// Optional feature macro: PC_ALIGN_CHECK_EN
//   defined   : branch / buffered targets with nonzero low bits (below STEP)
//               are not loaded; pc_o holds and misalign_o pulses for one cycle.
//   undefined : targets are loaded verbatim, misalign_o is always 0.
//
// Ports:
//   clk                      in   rising-edge clock
//   rst                      in   asynchronous active-low reset
//   stall_i[STALL_W]         in   stall vector, only bit 0 freezes the PC
//   flush_i                  in   exception/trap redirect request
//   new_pc_i[ADDR_W]         in   flush target
//   branch_flag_i            in   branch/jump taken
//   branch_target_address_i  in   branch target
//   fetch_ready_i            in   instruction memory accepts pc_o this cycle
//   pc_o[ADDR_W]             out  current fetch address
//   ce_o                     out  fetch enable to instruction memory
//   redirect_pending_o       out  a buffered branch is waiting to be applied
//   misalign_o               out  misaligned redirect target was dropped
//   fetch_cnt_o[CNT_W]       out  count of accepted fetches (wraps)
// -----------------------------------------------------------------------------
module pc_gen_unit #(
    parameter int unsigned          ADDR_W       = 32,
    parameter logic [ADDR_W-1:0]    RESET_VECTOR = '0,
    parameter int unsigned          STEP         = 4,
    parameter int unsigned          STALL_W      = 6,
    parameter int unsigned          CNT_W        = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall_i,
    input  logic                flush_i,
    input  logic [ADDR_W-1:0]   new_pc_i,
    input  logic                branch_flag_i,
    input  logic [ADDR_W-1:0]   branch_target_address_i,
    input  logic                fetch_ready_i,
    output logic [ADDR_W-1:0]   pc_o,
    output logic                ce_o,
    output logic                redirect_pending_o,
    output logic                misalign_o,
    output logic [CNT_W-1:0]    fetch_cnt_o
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    // Low address bits that must be zero for a target to be STEP-aligned.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STEP - 1);
    localparam logic [ADDR_W-1:0] STEP_INC   = ADDR_W'(STEP);

    function automatic logic misaligned(input logic [ADDR_W-1:0] addr);
        return ALIGN_CHK && (|(addr & ALIGN_MASK));
    endfunction

    state_t              state_q,    state_d;
    logic [ADDR_W-1:0]   pc_q,       pc_d;
    logic                ce_q,       ce_d;
    logic                pend_q,     pend_d;
    logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
    logic                misalign_q, misalign_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic                adv;

    // Only stall bit 0 matters; the rest of the vector is intentionally ignored.
    logic unused_stall_bits;
    assign unused_stall_bits = ^stall_i;

    assign adv = ce_q & ~stall_i[0] & fetch_ready_i;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ce_d        = ce_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        misalign_d  = 1'b0;
        // Redirect cycles still count: the old pc_o was accepted that cycle.
        cnt_d       = adv ? cnt_q + CNT_W'(1) : cnt_q;

        case (state_q)
            BOOT: begin
                // First fetch is RESET_VECTOR itself; every request is ignored here.
                ce_d    = 1'b1;
                state_d = RUN;
            end

            RUN: begin
                if (flush_i) begin
                    pc_d = new_pc_i;
                end else if (branch_flag_i && adv) begin
                    if (misaligned(branch_target_address_i)) begin
                        misalign_d = 1'b1;
                    end else begin
                        pc_d = branch_target_address_i;
                    end
                end else if (branch_flag_i) begin
                    // Fetch not accepted: remember the redirect instead of losing it.
                    pend_addr_d = branch_target_address_i;
                    pend_d      = 1'b1;
                    state_d     = HOLD;
                end else if (adv) begin
                    pc_d = pc_q + STEP_INC;
                end
            end

            HOLD: begin
                // Younger branches are wrong-path; only flush can pre-empt the buffer.
                if (flush_i) begin
                    pc_d        = new_pc_i;
                    pend_d      = 1'b0;
                    pend_addr_d = '0;
                    state_d     = RUN;
                end else if (adv) begin
                    if (misaligned(pend_addr_q)) begin
                        misalign_d = 1'b1;
                    end else begin
                        pc_d = pend_addr_q;
                    end
                    pend_d      = 1'b0;
                    pend_addr_d = '0;
                    state_d     = RUN;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= BOOT;
            pc_q        <= RESET_VECTOR;
            ce_q        <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            misalign_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ce_q        <= ce_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            misalign_q  <= misalign_d;
            cnt_q       <= cnt_d;
        end
    end

    assign pc_o               = pc_q;
    assign ce_o               = ce_q;
    assign redirect_pending_o = pend_q;
    assign misalign_o         = misalign_q;
    assign fetch_cnt_o        = cnt_q;

endmodule
